zl_fifo_sync: RTL and testbench

ZL_FIFO_SYNC -- requirements
Module: zl_fifo_sync

---
 rtl/zl_fifo_sync_pkg.sv | 19 +
 rtl/zl_sdp_ram.sv | 30 +++
 rtl/zl_fifo_sync.sv | 93 +++++++++
 tb/tb_zl_fifo_sync.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zl_fifo_sync_pkg.sv
// Shared definitions for the zl_fifo_sync block: width helper and drop-counter width.
package zl_fifo_sync_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    // Ceiling log2; clog2(1) = 0, clog2(17) = 5.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/zl_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read of a registered address.
module zl_sdp_ram
    import zl_fifo_sync_pkg::*;
#(
    parameter int unsigned Data_width = 8,
    parameter int unsigned Addr_width = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [Addr_width-1:0] wr_addr,
    input  logic [Data_width-1:0] wr_data,
    input  logic [Addr_width-1:0] rd_addr,
    output logic [Data_width-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << Addr_width;

    logic [Data_width-1:0] mem [DEPTH];

    // Write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: rd_addr comes straight from a register in the parent.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/zl_fifo_sync.sv
// Synchronous showahead FIFO with req/ack handshakes, backpressure or drop-when-full.
module zl_fifo_sync
    import zl_fifo_sync_pkg::*;
#(
    parameter int unsigned Data_width   = 8,
    parameter int unsigned Addr_width   = 4,
    parameter int unsigned Afull_level  = (1 << Addr_width) - 2,
    parameter int unsigned Aempty_level = 2,
    parameter int unsigned Drop_mode    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_req,
    output logic                  in_ack,
    input  logic [Data_width-1:0] in_data,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [Data_width-1:0] out_data,
    output logic [Addr_width:0]   used,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned DEPTH = 1 << Addr_width;
    // One extra bit over the address distinguishes full from empty.
    localparam int unsigned PTR_W = clog2(DEPTH + 1);

    if (Afull_level > DEPTH || Aempty_level >= DEPTH) begin : g_bad_levels
        $error("zl_fifo_sync: Afull_level/Aempty_level out of range for depth");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic             drop;

    // Status flags derived purely from the registered pointers.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                          (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign used         = wr_ptr - rd_ptr;
    assign almost_full  = (32'(used) >= Afull_level);
    assign almost_empty = (32'(used) <= Aempty_level);
    assign out_req      = !empty;

    // Handshake and transfer qualification; flush blocks any pointer movement.
    assign in_ack = !rst && in_req && ((Drop_mode != 0) || !full);
    assign wr_en  = in_ack && !full && !flush;
    assign rd_en  = out_req && out_ack && !flush;
    assign drop   = (Drop_mode != 0) && in_ack && full;

    // Pointer registers; rst and flush both return them to zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Saturating count of words discarded while full; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    zl_sdp_ram #(
        .Data_width (Data_width),
        .Addr_width (Addr_width)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_ptr[Addr_width-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[Addr_width-1:0]),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_zl_fifo_sync.sv
// Bench: one backpressure FIFO (dut0) and one drop-mode FIFO (dut1) against a queue model.
module tb_zl_fifo_sync;
    import zl_fifo_sync_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned UW    = clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [1:0]     flush;
    logic [1:0]     in_req;
    logic [1:0]     out_ack;
    logic [DW-1:0]  in_data  [2];
    logic           in_ack_o [2];
    logic           out_req_o[2];
    logic [DW-1:0]  out_data_o[2];
    logic [UW-1:0]  used_o   [2];
    logic           full_o   [2];
    logic           empty_o  [2];
    logic           afull_o  [2];
    logic           aempty_o [2];
    logic [15:0]    drop_o   [2];

    zl_fifo_sync #(.Drop_mode(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_req(in_req[0]), .in_ack(in_ack_o[0]),
        .in_data(in_data[0]), .out_req(out_req_o[0]), .out_ack(out_ack[0]),
        .out_data(out_data_o[0]), .used(used_o[0]), .full(full_o[0]), .empty(empty_o[0]),
        .almost_full(afull_o[0]), .almost_empty(aempty_o[0]), .drop_cnt(drop_o[0])
    );

    zl_fifo_sync #(.Drop_mode(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_req(in_req[1]), .in_ack(in_ack_o[1]),
        .in_data(in_data[1]), .out_req(out_req_o[1]), .out_ack(out_ack[1]),
        .out_data(out_data_o[1]), .used(used_o[1]), .full(full_o[1]), .empty(empty_o[1]),
        .almost_full(afull_o[1]), .almost_empty(aempty_o[1]), .drop_cnt(drop_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, m, $time, act, exp);
        end
    endtask

    // Reference model: ordered list of stored words plus a drop counter per instance.
    logic [DW-1:0] mq [2][DEPTH];
    int            mcnt [2];
    int unsigned   mdrop[2];
    bit            model_ok = 1'b0;

    task automatic model_compare(input int m);
        bit exp_ack;
        exp_ack = rst ? 1'b0 : ((m == 1) ? in_req[m] : (in_req[m] && mcnt[m] < DEPTH));
        chk("used", m, 32'(used_o[m]), 32'(mcnt[m]));
        chk("empty", m, 32'(empty_o[m]), 32'(mcnt[m] == 0));
        chk("full", m, 32'(full_o[m]), 32'(mcnt[m] == DEPTH));
        chk("almost_full", m, 32'(afull_o[m]), 32'(mcnt[m] >= DEPTH - 2));
        chk("almost_empty", m, 32'(aempty_o[m]), 32'(mcnt[m] <= 2));
        chk("out_req", m, 32'(out_req_o[m]), 32'(mcnt[m] > 0));
        if (mcnt[m] > 0) chk("out_data", m, 32'(out_data_o[m]), 32'(mq[m][0]));
        chk("in_ack", m, 32'(in_ack_o[m]), 32'(exp_ack));
        chk("drop_cnt", m, 32'(drop_o[m]), mdrop[m]);
    endtask

    task automatic model_update(input int m);
        bit do_rd;
        bit do_wr;
        if (rst) begin
            mcnt[m]  = 0;
            mdrop[m] = 0;
        end else begin
            if (m == 1 && in_req[m] && mcnt[m] == DEPTH && mdrop[m] < 32'hFFFF) mdrop[m]++;
            if (flush[m]) begin
                mcnt[m] = 0;
            end else begin
                do_rd = out_ack[m] && (mcnt[m] > 0);
                do_wr = in_req[m] && (mcnt[m] < DEPTH);
                if (do_rd) begin
                    for (int k = 0; k < DEPTH - 1; k++) mq[m][k] = mq[m][k+1];
                    mcnt[m]--;
                end
                if (do_wr) begin
                    mq[m][mcnt[m]] = in_data[m];
                    mcnt[m]++;
                end
            end
        end
    endtask

    // Compare process: inputs settle at the falling edge, outputs checked 2 units later.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                if (model_ok) model_compare(m);
                model_update(m);
            end
            if (rst) model_ok = 1'b1;
        end
    end

    task automatic drv(input int m, input bit f, input bit r, input logic [DW-1:0] d, input bit a);
        flush[m]   = f;
        in_req[m]  = r;
        in_data[m] = d;
        out_ack[m] = a;
    endtask

    task automatic idle_all();
        drv(0, 0, 0, '0, 0);
        drv(1, 0, 0, '0, 0);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_reset(input int m);
        chk("rst_used", m, 32'(used_o[m]), 0);
        chk("rst_empty", m, 32'(empty_o[m]), 1);
        chk("rst_aempty", m, 32'(aempty_o[m]), 1);
        chk("rst_full", m, 32'(full_o[m]), 0);
        chk("rst_afull", m, 32'(afull_o[m]), 0);
        chk("rst_out_req", m, 32'(out_req_o[m]), 0);
        chk("rst_drop_cnt", m, 32'(drop_o[m]), 0);
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int p_wr;
        int p_rd;
        rst = 1'b1;
        idle_all();
        nxt(); drv(0, 0, 1, 8'h11, 0); drv(1, 0, 1, 8'h22, 0); #3;
        chk("ack_in_rst", 0, 32'(in_ack_o[0]), 0);
        chk("ack_in_rst", 1, 32'(in_ack_o[1]), 0);
        nxt(); rst = 1'b0; idle_all(); #3;
        chk_reset(0); chk_reset(1);

        // Single word into empty FIFO: visible one edge later.
        nxt(); drv(0, 0, 1, 8'hA5, 0); #3;
        chk("fallthru_out_req", 0, 32'(out_req_o[0]), 0);
        chk("fallthru_in_ack", 0, 32'(in_ack_o[0]), 1);
        nxt(); drv(0, 0, 0, 8'h00, 0); #3;
        chk("fallthru_out_req", 0, 32'(out_req_o[0]), 1);
        chk("fallthru_out_data", 0, 32'(out_data_o[0]), 32'h A5);
        nxt(); drv(0, 0, 0, 8'h00, 1);
        nxt(); drv(0, 0, 0, 8'h00, 0); #3;
        chk("fallthru_empty", 0, 32'(empty_o[0]), 1);

        // Fill 0..15 with no reads.
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(0, 0, 1, 8'(i), 0); #3;
            chk("fill_in_ack", 0, 32'(in_ack_o[0]), 1);
            chk("fill_afull", 0, 32'(afull_o[0]), 32'(i >= 14));
        end
        nxt(); drv(0, 0, 1, 8'h63, 0); #3;
        chk("full_flag", 0, 32'(full_o[0]), 1);
        chk("full_used", 0, 32'(used_o[0]), 16);
        chk("full_in_ack", 0, 32'(in_ack_o[0]), 0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(0, 0, 0, 8'h00, 1); #3;
            chk("drain_data", 0, 32'(out_data_o[0]), 32'(i));
            chk("drain_aempty", 0, 32'(aempty_o[0]), 32'((16 - i) <= 2));
        end
        nxt(); idle_all(); #3;
        chk("drained_empty", 0, 32'(empty_o[0]), 1);
        chk("drained_used", 0, 32'(used_o[0]), 0);

        // Simultaneous offer and take while full: backpressure means read only.
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(0, 0, 1, 8'(8'h40 + i), 0);
        end
        nxt(); drv(0, 0, 1, 8'h77, 1); #3;
        chk("full_rw_in_ack", 0, 32'(in_ack_o[0]), 0);
        for (int k = 0; k < 7; k++) begin
            nxt(); drv(0, 0, 0, 8'h00, 1); #3;
            if (k == 0) chk("full_rw_used", 0, 32'(used_o[0]), 15);
        end
        for (int k = 0; k < 100; k++) begin
            nxt(); drv(0, 0, 1, 8'($urandom), 1); #3;
            chk("steady_used", 0, 32'(used_o[0]), 8);
        end
        nxt(); drv(0, 0, 1, 8'hEE, 0); #3;
        chk("steady_end_used", 0, 32'(used_o[0]), 8);

        // Flush overrides a concurrent write.
        nxt(); drv(0, 1, 1, 8'hCC, 0); #3;
        chk("pre_flush_used", 0, 32'(used_o[0]), 9);
        nxt(); idle_all(); #3;
        chk("flush_used", 0, 32'(used_o[0]), 0);
        chk("flush_empty", 0, 32'(empty_o[0]), 1);
        nxt(); #3;
        chk("flush_no_write", 0, 32'(out_req_o[0]), 0);

        // Drop mode: offers while full are acknowledged and discarded.
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(1, 0, 1, 8'(8'h10 + i), 0);
        end
        for (int k = 0; k < 3; k++) begin
            nxt(); drv(1, 0, 1, 8'(8'hF0 + k), 0); #3;
            chk("drop_in_ack", 1, 32'(in_ack_o[1]), 1);
            chk("drop_full", 1, 32'(full_o[1]), 1);
        end
        nxt(); idle_all(); #3;
        chk("drop_cnt3", 1, 32'(drop_o[1]), 3);
        chk("drop_used", 1, 32'(used_o[1]), 16);
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(1, 0, 0, 8'h00, 1); #3;
            chk("drop_drain_data", 1, 32'(out_data_o[1]), 32'(8'h10 + i));
        end
        nxt(); idle_all();
        for (int i = 0; i < 16; i++) begin
            nxt(); drv(1, 0, 1, 8'(i), 0);
        end
        for (int k = 0; k < 70000; k++) begin
            nxt(); drv(1, 0, 1, 8'(k), 0);
        end
        nxt(); idle_all(); #3;
        chk("drop_saturate", 1, 32'(drop_o[1]), 32'hFFFF);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) begin
            nxt(); drv(0, 0, 1, 8'(i), 0);
        end
        nxt(); rst = 1'b1; drv(0, 0, 1, 8'h55, 1); drv(1, 0, 1, 8'h66, 1); #3;
        chk("ack_in_rst", 0, 32'(in_ack_o[0]), 0);
        chk("ack_in_rst", 1, 32'(in_ack_o[1]), 0);
        nxt(); rst = 1'b0; idle_all(); #3;
        chk_reset(0); chk_reset(1);

        // Randomized traffic with phase-varying write/read bias.
        p_wr = 2; p_rd = 2;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if (c % 250 == 0) begin
                p_wr = int'($urandom_range(0, 4));
                p_rd = int'($urandom_range(0, 4));
            end
            rst = ($urandom_range(0, 799) == 0);
            for (int m = 0; m < 2; m++) begin
                drv(m, $urandom_range(0, 99) == 0, int'($urandom_range(0, 3)) < p_wr,
                    8'($urandom), int'($urandom_range(0, 3)) < p_rd);
            end
        end
        nxt(); rst = 1'b0; idle_all();
        nxt(); #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
